// File: rtl/mover_2d_stream_source.sv
// mover_2d_stream_source
//   Reads a WIDTH x HEIGHT window from a synchronous-read memory, row-major,
//   and presents it as a valid/ready stream to the activation/mover pipeline.
//
//   Optional feature macro: MOVER_2D_SOURCE_STRIDE_EN
//     defined   : row r starts at SRC_ADDR + r*STRIDE
//     undefined : rows are contiguous (row r starts at SRC_ADDR + r*WIDTH),
//                 and STRIDE is ignored
//
//   Ports
//     RESET_N, CLK             async active-low reset, clock
//     GO / BUSY / DONE         start pulse, transfer in progress, 1-cycle end pulse
//     SRC_ADDR, WIDTH, HEIGHT,
//     STRIDE                   window description, latched on an accepted GO
//     MEM_RD_EN, MEM_ADDR,
//     MEM_DATA                 memory read port; data returns one cycle after read
//     OUT_READY, OUT_VALID,
//     OUT_DATA, OUT_USER,
//     OUT_LAST                 output stream; OUT_USER[0] = end of row,
//                              OUT_LAST = end of frame
module mover_2d_stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  RESET_N,
  input  logic                  CLK,
  input  logic                  GO,
  output logic                  BUSY,
  output logic                  DONE,
  input  logic [ADDR_WIDTH-1:0] SRC_ADDR,
  input  logic [CNT_WIDTH-1:0]  WIDTH,
  input  logic [CNT_WIDTH-1:0]  HEIGHT,
  input  logic [ADDR_WIDTH-1:0] STRIDE,
  output logic                  MEM_RD_EN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  input  logic                  OUT_READY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [USER_WIDTH-1:0] OUT_USER,
  output logic                  OUT_LAST
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  eol;
    logic                  last;
  } beat_t;

  state_e                state_q, state_d;

  // Latched window and read walker
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [ADDR_WIDTH-1:0] step_q;
  logic [CNT_WIDTH-1:0]  width_q, height_q;
  logic [CNT_WIDTH-1:0]  col_q, row_q;

  // Read in flight: its row/frame markers travel alongside it
  logic                  inflight_q;
  logic                  tag_eol_q, tag_last_q;

  // 2-entry output buffer
  beat_t                 buf_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            cnt_q;

  logic                  done_q;

  logic                  go_ok, go_zero;
  logic                  pop, final_pop, rd_en;
  logic                  col_end, frame_end;
  logic [1:0]            occ_net;
  beat_t                 head;

`ifndef MOVER_2D_SOURCE_STRIDE_EN
  logic                  stride_unused;
  assign stride_unused = ^STRIDE;
`endif

  assign go_ok   = (state_q == IDLE) && GO && (WIDTH != '0) && (HEIGHT != '0);
  assign go_zero = (state_q == IDLE) && GO && ((WIDTH == '0) || (HEIGHT == '0));

  assign head      = buf_q[rptr_q];
  assign OUT_VALID = (cnt_q != 2'd0);
  assign OUT_DATA  = head.data;
  assign OUT_USER  = USER_WIDTH'(head.eol);
  assign OUT_LAST  = head.last;
  assign DONE      = done_q;
  assign MEM_ADDR  = addr_q;

  assign pop       = OUT_VALID && OUT_READY;
  assign final_pop = pop && head.last;

  // Occupancy counted after this cycle's pop, so a drained slot can be
  // refilled in the same cycle and the stream keeps one beat per cycle.
  assign occ_net   = cnt_q - 2'(pop) + 2'(inflight_q);

  assign col_end   = (col_q == width_q - CNT_WIDTH'(1));
  assign frame_end = col_end && (row_q == height_q - CNT_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    BUSY      = 1'b0;
    MEM_RD_EN = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_ok) state_d = RUN;
      end
      RUN: begin
        BUSY  = 1'b1;
        rd_en = (occ_net < 2'd2);
        if (rd_en && frame_end) state_d = DRAIN;
      end
      DRAIN: begin
        BUSY = 1'b1;
        if (final_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    MEM_RD_EN = rd_en;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q     <= '0;
      row_base_q <= '0;
      step_q     <= '0;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      tag_eol_q  <= 1'b0;
      tag_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= go_zero || final_pop;
      inflight_q <= rd_en;
      if (rd_en) begin
        tag_eol_q  <= col_end;
        tag_last_q <= frame_end;
      end

      if (go_ok) begin
        addr_q     <= SRC_ADDR;
        row_base_q <= SRC_ADDR;
        width_q    <= WIDTH;
        height_q   <= HEIGHT;
        col_q      <= '0;
        row_q      <= '0;
`ifdef MOVER_2D_SOURCE_STRIDE_EN
        step_q     <= STRIDE;
`else
        step_q     <= ADDR_WIDTH'(WIDTH);
`endif
      end else if (rd_en) begin
        if (col_end) begin
          col_q      <= '0;
          row_q      <= row_q + CNT_WIDTH'(1);
          row_base_q <= row_base_q + step_q;
          addr_q     <= row_base_q + step_q;
        end else begin
          col_q  <= col_q + CNT_WIDTH'(1);
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end

      if (inflight_q) begin
        buf_q[wptr_q] <= '{data: MEM_DATA, eol: tag_eol_q, last: tag_last_q};
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_mover_2d_stream_source.sv
module tb_mover_2d_stream_source;
  localparam int DW = 32, UW = 4, AW = 16, CW = 12;

  logic          RESET_N, CLK, GO, BUSY, DONE;
  logic [AW-1:0] SRC_ADDR, STRIDE, MEM_ADDR;
  logic [CW-1:0] WIDTH, HEIGHT;
  logic          MEM_RD_EN, OUT_READY, OUT_VALID, OUT_LAST;
  logic [DW-1:0] MEM_DATA, OUT_DATA;
  logic [UW-1:0] OUT_USER;

  mover_2d_stream_source #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .RESET_N(RESET_N), .CLK(CLK), .GO(GO), .BUSY(BUSY), .DONE(DONE),
    .SRC_ADDR(SRC_ADDR), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .STRIDE(STRIDE),
    .MEM_RD_EN(MEM_RD_EN), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .OUT_USER(OUT_USER), .OUT_LAST(OUT_LAST));

  initial begin CLK = 0; forever #5 CLK = ~CLK; end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory: content is a function of address and a per-test salt
  logic [15:0] salt = 16'h1234;
  function automatic logic [31:0] fmem(input logic [15:0] a);
    return {a ^ salt, ~a};
  endfunction
  always @(posedge CLK) if (MEM_RD_EN) MEM_DATA <= fmem(MEM_ADDR);

  // Reference model: a list of expected reads and beats per accepted frame
  typedef struct { logic [31:0] data; logic [3:0] user; logic last; } beat_t;
  beat_t       exp_beat[$];
  logic [15:0] exp_rd[$];
  logic [15:0] rd_log[$];
  logic        busy_m = 0, done_m = 0;
  int          cyc = 0, beats = 0, outst = 0, done_cnt = 0;
  int          go_cyc = -1, first_rd = -1, first_vld = -1, last_hs = -1, done_cyc = -1;
  logic [5:0]  eol_mask, last_mask;
  logic        prev_stall = 0;
  logic [37:0] prev_out;
  int          rdy_pct = 100;

  always @(negedge CLK) begin : compare
    logic  busy_nx, done_nx;
    beat_t b;
    int    step;
    cyc++;
    if (!RESET_N) begin
      chk("reset_outputs", {BUSY, DONE, MEM_RD_EN, MEM_ADDR, OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST}, 0);
      exp_beat.delete(); exp_rd.delete();
      busy_m = 0; done_m = 0; outst = 0; prev_stall = 0;
    end else begin
      chk("busy", BUSY, busy_m);
      chk("done", DONE, done_m);
      if (DONE) begin done_cnt++; done_cyc = cyc; end
      busy_nx = busy_m; done_nx = 0;
      if (MEM_RD_EN) begin
        if (exp_rd.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rd_extra: got read at %0h expected none", MEM_ADDR);
        end else chk("rd_addr", MEM_ADDR, exp_rd.pop_front());
        rd_log.push_back(MEM_ADDR);
        if (first_rd < 0) first_rd = cyc;
        outst++;
      end
      if (prev_stall) chk("stall_stable", {OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST}, prev_out);
      if (OUT_VALID && first_vld < 0) first_vld = cyc;
      if (OUT_VALID && OUT_READY) begin
        if (exp_beat.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL beat_extra: got %0h expected none", OUT_DATA);
        end else begin
          b = exp_beat.pop_front();
          chk("beat", {OUT_DATA, OUT_USER, OUT_LAST}, {b.data, b.user, b.last});
          if (b.last) begin busy_nx = 0; done_nx = 1; end
        end
        if (beats < 6) begin eol_mask[beats] = OUT_USER[0]; last_mask[beats] = OUT_LAST; end
        beats++; outst--; last_hs = cyc;
      end
      if (MEM_RD_EN) chk("outstanding_le2", (outst <= 2), 1);
      prev_stall = OUT_VALID && !OUT_READY;
      prev_out   = {OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST};
      if (GO && !busy_m) begin
        if (WIDTH == 0 || HEIGHT == 0) done_nx = 1;
        else begin
          busy_nx = 1; go_cyc = cyc;
`ifdef MOVER_2D_SOURCE_STRIDE_EN
          step = int'(STRIDE);
`else
          step = int'(WIDTH);
`endif
          for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++) begin
              logic [15:0] a;
              a = 16'(int'(SRC_ADDR) + r*step + c);
              exp_rd.push_back(a);
              exp_beat.push_back('{fmem(a), (c == WIDTH-1) ? 4'd1 : 4'd0,
                                   (c == WIDTH-1) && (r == HEIGHT-1)});
            end
        end
      end
      busy_m = busy_nx; done_m = done_nx;
    end
  end

  initial begin : ready_gen
    OUT_READY = 0;
    forever begin
      @(posedge CLK); #1;
      OUT_READY = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic clear_logs();
    rd_log.delete(); beats = 0; first_rd = -1; first_vld = -1;
    last_hs = -1; done_cyc = -1; done_cnt = 0; eol_mask = 0; last_mask = 0;
  endtask

  task automatic start(input logic [15:0] src, input int w, input int h, input logic [15:0] st);
    @(posedge CLK); #1;
    SRC_ADDR = src; WIDTH = CW'(w); HEIGHT = CW'(h); STRIDE = st; GO = 1;
    @(posedge CLK); #1;
    GO = 0;
    SRC_ADDR = 16'($urandom); WIDTH = CW'($urandom_range(0, 9));
    HEIGHT = CW'($urandom_range(0, 9)); STRIDE = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (DONE) begin seen = 1; break; end
    end
    #1;
    chk("done_within_budget", seen, 1);
  endtask

  task automatic frame_end_checks(input int n);
    chk("beat_count", beats, n);
    chk("model_beats_drained", exp_beat.size(), 0);
    chk("model_reads_drained", exp_rd.size(), 0);
  endtask

  int exp_a[6];

  initial begin
    RESET_N = 0; GO = 0; SRC_ADDR = 0; WIDTH = 0; HEIGHT = 0; STRIDE = 0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1;
    repeat (2) @(posedge CLK);

    // Basic 3x2 frame, always ready
    rdy_pct = 100; clear_logs();
    start(16'h0010, 3, 2, 16'h0);
    wait_done(100);
    frame_end_checks(6);
    chk("basic_nreads", rd_log.size(), 6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++) chk("basic_addr", rd_log[i], 16'h10 + i);
    chk("basic_rd_latency", first_rd - go_cyc, 1);
    chk("basic_vld_latency", first_vld - go_cyc, 3);
    chk("basic_consecutive", last_hs - first_vld, 5);
    chk("basic_done_after_last", done_cyc - last_hs, 1);
    chk("basic_eol_mask", eol_mask, 6'b100100);
    chk("basic_last_mask", last_mask, 6'b100000);

    // Backpressure 4x4 at 30% ready
    salt = 16'($urandom); rdy_pct = 30; clear_logs();
    start(16'($urandom), 4, 4, 16'h0);
    wait_done(1000);
    frame_end_checks(16);

    // Random frames, random ready
    for (int t = 0; t < 6; t++) begin
      int w, h;
      w = $urandom_range(1, 6); h = $urandom_range(1, 4);
      salt = 16'($urandom); rdy_pct = $urandom_range(20, 100); clear_logs();
      start(16'($urandom), w, h, 16'($urandom_range(0, 15)));
      wait_done(1000);
      frame_end_checks(w*h);
    end

    // Stride / contiguous rows
    rdy_pct = 100; clear_logs();
`ifdef MOVER_2D_SOURCE_STRIDE_EN
    exp_a = '{0, 1, 8, 9, 16, 17};
`else
    exp_a = '{0, 1, 2, 3, 4, 5};
`endif
    start(16'h0, 2, 3, 16'd8);
    wait_done(100);
    frame_end_checks(6);
    chk("stride_nreads", rd_log.size(), 6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++) chk("stride_addr", rd_log[i], exp_a[i]);

    // Zero-size frame
    clear_logs();
    start(16'h40, 0, 5, 16'h0);
    wait_done(10);
    repeat (3) @(negedge CLK);
    #1;
    chk("zero_no_reads", rd_log.size(), 0);
    chk("zero_no_valid", first_vld, -1);
    chk("zero_done_once", done_cnt, 1);

    // GO while busy is ignored
    rdy_pct = 0; clear_logs();
    start(16'h100, 4, 4, 16'h0);
    repeat (5) @(posedge CLK);
    start(16'h200, 2, 2, 16'h0);
    rdy_pct = 100;
    wait_done(300);
    repeat (4) @(negedge CLK);
    #1;
    frame_end_checks(16);
    chk("busy_go_nreads", rd_log.size(), 16);
    if (rd_log.size() > 0) chk("busy_go_first_addr", rd_log[0], 16'h100);
    chk("busy_go_done_once", done_cnt, 1);

    // Address wrap
    clear_logs();
    start(16'hFFFE, 4, 1, 16'h0);
    wait_done(100);
    frame_end_checks(4);
    exp_a = '{16'hFFFE, 16'hFFFF, 0, 1, 0, 0};
    chk("wrap_nreads", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("wrap_addr", rd_log[i], exp_a[i]);

    // Reset in the middle of a 4x4 frame
    clear_logs();
    start(16'h0, 4, 4, 16'h0);
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK); #1;
      if (beats >= 2) break;
    end
    RESET_N = 0;
    #1;
    chk("midreset_outputs_zero", {BUSY, DONE, MEM_RD_EN, MEM_ADDR, OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST}, 0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1;
    repeat (2) @(posedge CLK);
    salt = 16'($urandom); clear_logs();
    start(16'h30, 2, 1, 16'h0);
    wait_done(100);
    repeat (3) @(negedge CLK);
    #1;
    frame_end_checks(2);
    chk("post_reset_nreads", rd_log.size(), 2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/mover_2d_stream_source.md
MOVER_2D_STREAM_SOURCE -- requirements
Module: mover_2d_stream_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream and memory data width in bits.
REQ-002 SHALL have parameter USER_WIDTH, default DATA_WIDTH/8, sideband width; must be at least 1.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, memory word-address width.
REQ-004 SHALL have parameter CNT_WIDTH, default 12, width of the WIDTH and HEIGHT fields.
REQ-005 SHALL have ports, in order: RESET_N in 1 (active-low reset); CLK in 1 (clock). One clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports GO in 1 (start pulse) and BUSY out 1 (transfer in progress).
REQ-007 SHALL have port DONE out 1, a one-cycle completion pulse.
REQ-008 SHALL have ports SRC_ADDR in ADDR_WIDTH (first word address), WIDTH in CNT_WIDTH (elements per row) and HEIGHT in CNT_WIDTH (rows).
REQ-009 SHALL have port STRIDE in ADDR_WIDTH (row-start to row-start distance in words).
REQ-010 SHALL have ports MEM_RD_EN out 1, MEM_ADDR out ADDR_WIDTH and MEM_DATA in DATA_WIDTH; the memory is synchronous read, and MEM_DATA is valid one cycle after the edge that samples MEM_RD_EN.
REQ-011 SHALL have ports OUT_READY in 1, OUT_VALID out 1, OUT_DATA out DATA_WIDTH, OUT_USER out USER_WIDTH and OUT_LAST out 1; this is the valid/ready stream feeding the activation/mover pipeline.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DRAIN with these transitions:
- IDLE->RUN on GO=1 with WIDTH!=0 and HEIGHT!=0;
- RUN->DRAIN after the last read is issued;
- DRAIN->IDLE on the final OUT handshake.
REQ-013 SHALL latch SRC_ADDR, WIDTH, HEIGHT and STRIDE at the edge that samples GO in IDLE; later changes to these inputs SHALL be ignored until the next start.
REQ-014 SHALL ignore GO while BUSY=1; BUSY SHALL be 1 in RUN and DRAIN.
REQ-015 SHALL, on GO with WIDTH==0 or HEIGHT==0, stay in IDLE, emit no beats and no reads, and pulse DONE on the next cycle.
REQ-016 SHALL drive MEM_RD_EN=1 in RUN only when (output buffer occupancy + reads in flight) < 2, using a 2-entry output buffer.
REQ-017 SHALL generate addresses row-major: within a row MEM_ADDR+1 per element, wrapping modulo 2^ADDR_WIDTH.
REQ-018 SHALL, with GO sampled at edge 0, assert MEM_RD_EN in cycle 0 and raise OUT_VALID after edge 2.
REQ-019 SHALL sustain one beat per cycle while OUT_READY=1.
REQ-020 SHALL transfer a beat when OUT_VALID&&OUT_READY; once asserted, OUT_VALID, OUT_DATA, OUT_USER and OUT_LAST SHALL hold stable until that handshake.
REQ-021 SHALL set OUT_USER[0]=1 on the last element of each row; all other OUT_USER bits SHALL be 0.
REQ-022 SHALL set OUT_LAST=1 only on the final element of the frame (last column, last row).
REQ-023 SHALL deliver exactly WIDTH*HEIGHT beats, in memory-read order, with no loss or duplication under any OUT_READY pattern.
REQ-024 SHALL pulse DONE one cycle after the final handshake and drop BUSY in that same cycle.

Reset
REQ-025 SHALL, on RESET_N=0 and asynchronously, enter IDLE and clear the buffer, in-flight count and all counters.
REQ-026 SHALL hold these outputs at 0 during reset: BUSY, DONE, MEM_RD_EN, MEM_ADDR, OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST.
REQ-027 SHALL abort a transfer on reset mid-operation with no further beats, and SHALL discard MEM_DATA returning after reset release.

Configuration
REQ-028 SHALL, when MOVER_2D_SOURCE_STRIDE_EN is defined, start row r at latched SRC_ADDR + r*STRIDE.
REQ-029 SHALL, when MOVER_2D_SOURCE_STRIDE_EN is undefined, ignore STRIDE and read rows contiguously (row r starts at SRC_ADDR + r*WIDTH).

Verification
REQ-030 SHALL cover a basic frame: SRC_ADDR=0x10, WIDTH=3, HEIGHT=2, OUT_READY=1 -> addresses 0x10..0x15, 6 beats on consecutive cycles, OUT_USER[0]=1 on beats 3 and 6, OUT_LAST on beat 6 only, DONE one cycle later.
REQ-031 SHALL cover backpressure: WIDTH=4, HEIGHT=4, OUT_READY random 30% high -> 16 beats match memory contents in order, data stable while stalled, never more than 2 reads outstanding+buffered.
REQ-032 SHALL cover stride: MOVER_2D_SOURCE_STRIDE_EN defined, SRC_ADDR=0, WIDTH=2, HEIGHT=3, STRIDE=8 -> addresses 0,1,8,9,16,17; with the macro undefined -> addresses 0..5.
REQ-033 SHALL cover zero size: WIDTH=0, HEIGHT=5, GO -> no MEM_RD_EN, no OUT_VALID, DONE pulses once next cycle; a GO issued while BUSY is ignored.
REQ-034 SHALL cover address wrap: ADDR_WIDTH=16, SRC_ADDR=0xFFFE, WIDTH=4, HEIGHT=1 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 SHALL cover reset mid-frame: RESET_N low during beat 3 of a 4x4 frame -> outputs 0 immediately; after release, a new GO (WIDTH=2, HEIGHT=1) yields exactly 2 correct beats.
